// File: rtl/osd_rst_sequencer.sv
// Sequenced system/CPU reset controller driven by the debug subnet's reset requests.
// System reset releases before CPU reset; each hold restarts while its request stays high.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SYS_HOLD | both resets asserted; counting SYS_HOLD_CYCLES once rst_req[0] drops
// CPU_HOLD | only cpu_rst asserted; counting CPU_HOLD_CYCLES once rst_req[1] drops
// RUN      | both resets released; waiting for a new request
module osd_rst_sequencer #(
  parameter int unsigned SYS_HOLD_CYCLES = 16,
  parameter int unsigned CPU_HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rst_req,
  output logic       sys_rst,
  output logic       cpu_rst,
  output logic       busy,
  output logic       rst_done
);

  localparam int unsigned MAX_HOLD = (SYS_HOLD_CYCLES > CPU_HOLD_CYCLES) ?
                                     SYS_HOLD_CYCLES : CPU_HOLD_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1);

  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST = CNT_W'(CPU_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    SYS_HOLD = 2'd0,
    CPU_HOLD = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYS_HOLD;
      cnt      <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b0;
      unique case (state)
        SYS_HOLD: begin
          if (rst_req[0]) begin
            cnt <= '0;
          end else if (cnt == SYS_LAST) begin
            state <= CPU_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CPU_HOLD: begin
          // system request wins over a concurrent CPU request
          if (rst_req[0]) begin
            state <= SYS_HOLD;
            cnt   <= '0;
          end else if (rst_req[1]) begin
            cnt <= '0;
          end else if (cnt == CPU_LAST) begin
            state    <= RUN;
            cnt      <= '0;
            rst_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          cnt <= '0;
          if (rst_req[0]) begin
            state <= SYS_HOLD;
          end else if (rst_req[1]) begin
            state <= CPU_HOLD;
          end
        end
        default: begin
          state <= SYS_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign sys_rst = (state == SYS_HOLD) | rst;
  assign cpu_rst = (state != RUN) | rst;
  assign busy    = (state != RUN) | rst;

endmodule

// File: tb/tb_osd_rst_sequencer.sv
// Bench for osd_rst_sequencer: two instances (holds 4/3 and 1/1) share stimulus and are
// compared every cycle against a model built on "cycles since the last request" windows.
module tb_osd_rst_sequencer;

  localparam int S0 = 4;
  localparam int C0 = 3;
  localparam int S1 = 1;
  localparam int C1 = 1;

  logic       clk;
  logic       rst;
  logic [1:0] rst_req;
  logic       sys_rst0, cpu_rst0, busy0, done0;
  logic       sys_rst1, cpu_rst1, busy1, done1;

  osd_rst_sequencer #(.SYS_HOLD_CYCLES(S0), .CPU_HOLD_CYCLES(C0)) dut0 (
    .clk(clk), .rst(rst), .rst_req(rst_req),
    .sys_rst(sys_rst0), .cpu_rst(cpu_rst0), .busy(busy0), .rst_done(done0)
  );

  osd_rst_sequencer #(.SYS_HOLD_CYCLES(S1), .CPU_HOLD_CYCLES(C1)) dut1 (
    .clk(clk), .rst(rst), .rst_req(rst_req),
    .sys_rst(sys_rst1), .cpu_rst(cpu_rst1), .busy(busy1), .rst_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: sys_rst is high for hold_s edges counted from the last system-condition edge;
  // cpu_rst is high for hold_s+hold_c edges from that point, or hold_c edges from the
  // last CPU-only request edge, whichever ends later. rst_done marks cpu_rst's fall.
  int   ecnt = 0;
  int   last_sys[2] = '{-1000, -1000};
  int   last_cpu[2] = '{-1000, -1000};
  int   hold_s[2]   = '{S0, S1};
  int   hold_c[2]   = '{C0, C1};
  logic prev_cpu[2] = '{1'b1, 1'b1};
  logic [7:0] exp_v;
  logic [7:0] obs_v;

  task automatic tick(input logic r, input logic [1:0] q);
    logic [3:0] e4 [2];
    logic s_on, c_on;
    rst     = r;
    rst_req = q;
    @(posedge clk);
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (r || q[0]) last_sys[i] = ecnt;
      else if (q[1]) last_cpu[i] = ecnt;
      s_on  = (ecnt - last_sys[i]) < hold_s[i];
      c_on  = ((ecnt - last_sys[i]) < (hold_s[i] + hold_c[i])) ||
              ((ecnt - last_cpu[i]) < hold_c[i]);
      e4[i] = {s_on | r, c_on | r, c_on | r, prev_cpu[i] & ~c_on};
      prev_cpu[i] = c_on;
    end
    exp_v = {e4[0], e4[1]};
    @(negedge clk);
    obs_v = {sys_rst0, cpu_rst0, busy0, done0, sys_rst1, cpu_rst1, busy1, done1};
  endtask

  task automatic test_reset();
    int n_sys, n_cpu_only, n_done;
    n_sys = 0; n_cpu_only = 0; n_done = 0;
    for (int k = 0; k < 14; k++) begin
      tick(k < 2, 2'b00);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL power_on cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      n_sys      += int'(sys_rst0);
      n_cpu_only += int'(cpu_rst0 & ~sys_rst0);
      n_done     += int'(done0);
    end
    // first rst edge, then S0 cycles opened by the final rst edge
    vectors++;
    if (n_sys !== S0 + 1) begin
      miscompares++;
      $display("FAIL power_on_sys_len: got %0d want %0d", n_sys, S0 + 1);
    end
    vectors++;
    if (n_cpu_only !== C0) begin
      miscompares++;
      $display("FAIL power_on_cpu_len: got %0d want %0d", n_cpu_only, C0);
    end
    vectors++;
    if (n_done !== 1) begin
      miscompares++;
      $display("FAIL power_on_done_count: got %0d want 1", n_done);
    end
    vectors++;
    if (busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL power_on_busy_idle: got %b want 0", busy0);
    end
  endtask

  task automatic test_cpu_req();
    int n_sys, n_cpu, n_done;
    n_sys = 0; n_cpu = 0; n_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, (k < 5) ? 2'b10 : 2'b00);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL cpu_req cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      n_sys  += int'(sys_rst0);
      n_cpu  += int'(cpu_rst0);
      n_done += int'(done0);
    end
    vectors++;
    if (n_sys !== 0 || n_cpu !== 5 + C0 - 1 || n_done !== 1) begin
      miscompares++;
      $display("FAIL cpu_req_counts: got sys=%0d cpu=%0d done=%0d want 0 %0d 1",
               n_sys, n_cpu, n_done, 5 + C0 - 1);
    end
  endtask

  task automatic test_sys_pulse();
    int sys_fall, cpu_fall;
    sys_fall = -1; cpu_fall = -1;
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, (k == 0) ? 2'b01 : 2'b00);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL sys_pulse cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      if (sys_fall < 0 && !sys_rst0) sys_fall = k;
      if (cpu_fall < 0 && !cpu_rst0) cpu_fall = k;
    end
    vectors++;
    if (sys_fall !== S0 || cpu_fall !== S0 + C0) begin
      miscompares++;
      $display("FAIL sys_pulse_order: got sys_fall=%0d cpu_fall=%0d want %0d %0d",
               sys_fall, cpu_fall, S0, S0 + C0);
    end
  endtask

  task automatic test_sys_in_cpu_hold();
    int n_done;
    n_done = 0;
    // request, S0 cycles of SYS_HOLD, one CPU_HOLD cycle, then re-request at cnt=1
    for (int k = 0; k < 18; k++) begin
      tick(1'b0, (k == 0 || k == S0 + 2) ? 2'b01 : 2'b00);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL sys_in_cpu_hold cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
      if (k == S0 + 2) begin
        vectors++;
        if (sys_rst0 !== 1'b1) begin
          miscompares++;
          $display("FAIL sys_in_cpu_hold_reassert: got %b want 1", sys_rst0);
        end
      end
      n_done += int'(done0);
    end
    vectors++;
    if (n_done !== 1) begin
      miscompares++;
      $display("FAIL sys_in_cpu_hold_done: got %0d want 1", n_done);
    end
  endtask

  task automatic test_both_req();
    for (int k = 0; k < 16; k++) begin
      tick(1'b0, (k < 3) ? 2'b11 : (k < 5) ? 2'b10 : 2'b00);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL both_req cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_rst_abort();
    for (int k = 0; k < 18; k++) begin
      tick(k == S0 + 2, (k == 0) ? 2'b01 : 2'b00);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL rst_abort cyc %0d: got %b want %b", k, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] q;
    for (int k = 0; k < 400; k++) begin
      r = (k < 388) && ($urandom_range(0, 39) == 0);
      q = ((k < 388) && ($urandom_range(0, 5) == 0)) ? 2'($urandom_range(0, 3)) : 2'b00;
      tick(r, q);
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc %0d rst=%b req=%b: got %b want %b", k, r, q, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    rst_req = 2'b00;
    test_reset();
    test_cpu_req();
    test_sys_pulse();
    test_sys_in_cpu_hold();
    test_both_req();
    test_rst_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
